// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO behind the I2S receiver.
// Each strobe captures one {left,right} pair. The consumer reads pairs over a
// first-word-fall-through valid/ready interface. When a strobe arrives while
// the FIFO is full and nothing is read, the pair is dropped. Every drop sets a
// sticky flag and bumps a saturating counter.
module audio_sample_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] audio_ldata_in,
    input  logic [DATA_W-1:0] audio_rdata_in,
    input  logic              iStrobe,
    output logic [DATA_W-1:0] out_ldata,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [15:0]       drop_count,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    // Saturating increment for the drop counter: the counter holds at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                full;
    logic                rd_en;
    logic                wr_en;
    logic                drop;

    // A read in the same cycle frees a slot, so a full FIFO still accepts
    // the strobe when the consumer is taking the head pair.
    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign rd_en     = out_valid & out_ready;
    assign wr_en     = iStrobe & (~full | rd_en);
    assign drop      = iStrobe & full & ~rd_en;

    // The head pair comes straight out of the array, so the output is
    // first-word-fall-through.
    assign out_ldata = mem[rd_ptr][2*DATA_W-1:DATA_W];
    assign out_rdata = mem[rd_ptr][DATA_W-1:0];

    // Sample storage. There is no reset here: contents are don't-care
    // while they are not covered by level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {audio_ldata_in, audio_rdata_in};
        end
    end

    // Pointers and fill level. A write and a read in the same cycle leave
    // the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Overflow bookkeeping. A clear takes priority over a drop in the same
    // cycle, and that drop is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc16(drop_count);
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo, built around a queue scoreboard.
module tb_audio_sample_fifo;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] audio_ldata_in = '0;
    logic [DATA_W-1:0] audio_rdata_in = '0;
    logic              iStrobe = 1'b0;
    logic [DATA_W-1:0] out_ldata;
    logic [DATA_W-1:0] out_rdata;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [15:0]       drop_count;
    logic              clr_overflow = 1'b0;

    audio_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .audio_ldata_in (audio_ldata_in),
        .audio_rdata_in (audio_rdata_in),
        .iStrobe        (iStrobe),
        .out_ldata      (out_ldata),
        .out_rdata      (out_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clr_overflow   (clr_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: the pairs the FIFO should hold, plus the expected flags.
    logic [2*DATA_W-1:0] sb_q[$];
    logic                m_ovf = 1'b0;
    logic [15:0]         m_cnt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one clock cycle with the inputs as currently driven. Before the
    // edge, compare the outputs against the model and predict the cycle's
    // effect. After the edge, check the flags.
    task automatic tick();
        bit rd;
        bit wr;
        bit drp;
        check("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
        check("level", 64'(level), 64'(sb_q.size()));
        rd = (sb_q.size() != 0) && out_ready;
        if (rd) begin
            check("head_pair", 64'({out_ldata, out_rdata}), 64'(sb_q[0]));
        end
        wr  = iStrobe && ((sb_q.size() < DEPTH) || rd);
        drp = iStrobe && !wr;
        if (rd) void'(sb_q.pop_front());
        if (wr) sb_q.push_back({audio_ldata_in, audio_rdata_in});
        if (clr_overflow) begin
            m_ovf = 1'b0;
            m_cnt = '0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check("drop_count", 64'(drop_count), 64'(m_cnt));
    endtask

    task automatic strobe(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        audio_ldata_in = l;
        audio_rdata_in = r;
        iStrobe = 1'b1;
        tick();
        iStrobe = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && sb_q.size() != 0; i++) tick();
        out_ready = 1'b0;
        tick();
        check("drained_level", 64'(level), 64'd0);
    endtask

    initial begin
        // 1: reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_level", 64'(level), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 2: single write, visible the cycle after the strobe, then one read
        strobe(24'h123456, 24'hABCDEF);
        check("t2_valid", {63'd0, out_valid}, 64'd1);
        check("t2_ldata", 64'(out_ldata), 64'h123456);
        check("t2_rdata", 64'(out_rdata), 64'hABCDEF);
        check("t2_level", 64'(level), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_empty", {63'd0, out_valid}, 64'd0);

        // 3: fill, then a 17th strobe is dropped
        for (int i = 0; i < DEPTH; i++) strobe(DATA_W'(i), ~DATA_W'(i));
        strobe(24'd16, ~24'd16);
        check("t3_level", 64'(level), 64'd16);
        check("t3_ovf", {63'd0, overflow}, 64'd1);
        check("t3_cnt", 64'(drop_count), 64'd1);

        // 7: a clear coincident with another drop wins, and the drop is not counted
        clr_overflow = 1'b1;
        strobe(24'd99, 24'd99);
        clr_overflow = 1'b0;
        check("t7_ovf", {63'd0, overflow}, 64'd0);
        check("t7_cnt", 64'(drop_count), 64'd0);
        check("t7_level", 64'(level), 64'd16);
        drain();

        // 4: full FIFO, 17th strobe together with a read is accepted
        for (int i = 0; i < DEPTH; i++) strobe(DATA_W'(i), ~DATA_W'(i));
        out_ready = 1'b1;
        strobe(24'd16, ~24'd16);
        out_ready = 1'b0;
        check("t4_level", 64'(level), 64'd16);
        check("t4_ovf", {63'd0, overflow}, 64'd0);
        check("t4_head", 64'(out_ldata), 64'd1);
        drain();

        // 5: wrap-around with interleaved strobes and reads, plus back-to-back strobes
        for (int i = 0; i < 10; i++) strobe(24'h500 + DATA_W'(i), 24'h5F0 + DATA_W'(i));
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b0;
            strobe(24'h600 + DATA_W'(i), DATA_W'($urandom));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        drain();

        // 6: reset mid-drain discards contents immediately
        for (int i = 0; i < 5; i++) strobe(24'h700 + DATA_W'(i), 24'h710 + DATA_W'(i));
        check("t6_pre_level", 64'(level), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_level", 64'(level), 64'd0);
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        sb_q.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        strobe(24'hC0FFEE, 24'hBEEF01);
        check("t6_level", 64'(level), 64'd1);
        check("t6_ldata", 64'(out_ldata), 64'hC0FFEE);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
